// File: rtl/led_gpio_ctrl.sv
// led_gpio_ctrl
// LED/GPIO output port for the peripheral bus window at 0xF0000000.
// Provides a latched DATA word (counter-mode select, LEDs, GPIO field),
// atomic LED bit-set / bit-clear, a prescaled hardware blink engine and
// combinational readback of the addressed register.
//
// Register map (addr):
//   0 DATA  : {gpio, led, cs}
//   1 SET   : led |= wdata[LED_W-1:0]          (reads live led_out)
//   2 CLR   : led &= ~wdata[LED_W-1:0]         (reads live led_out)
//   3 BLINK : blink_half = wdata[31:16], blink_mask = wdata[LED_W-1:0]
//
// led_out is held in its own register and computed from the next-state
// values, so a write is visible right after the edge that samples it and
// the LED pins only ever change on a clock edge.
module led_gpio_ctrl #(
    parameter int LED_W    = 8,
    parameter int GPIO_W   = 30 - LED_W,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              GPIOf0000000_we,
    input  logic [1:0]        addr,
    input  logic [31:0]       Peripheral_in,
    output logic [31:0]       rd_data,
    output logic [1:0]        counter_set,
    output logic [LED_W-1:0]  led_out,
    output logic [GPIO_W-1:0] GPIOf0
);

    // Prescaler needs at least one bit even when TICK_DIV is 1 (tick every cycle).
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_SET   = 2'd1;
    localparam logic [1:0] ADDR_CLR   = 2'd2;
    localparam logic [1:0] ADDR_BLINK = 2'd3;

    // Architectural state and its next-state values.
    logic [1:0]         cs_reg,         cs_next;
    logic [LED_W-1:0]   led_reg,        led_next;
    logic [GPIO_W-1:0]  gpio_reg,       gpio_next;
    logic [LED_W-1:0]   blink_mask_reg, blink_mask_next;
    logic [15:0]        blink_half_reg, blink_half_next;
    logic [PRESC_W-1:0] presc_reg,      presc_next;
    logic [15:0]        half_cnt_reg,   half_cnt_next;
    logic               phase_reg,      phase_next;
    logic [LED_W-1:0]   led_out_reg,    led_out_next;

    logic tick;
    logic blink_wr;

    assign blink_wr = GPIOf0000000_we && (addr == ADDR_BLINK);

    // Register-file write decode: DATA load, atomic SET/CLR, BLINK config.
    always_comb begin
        cs_next         = cs_reg;
        led_next        = led_reg;
        gpio_next       = gpio_reg;
        blink_mask_next = blink_mask_reg;
        blink_half_next = blink_half_reg;
        if (GPIOf0000000_we) begin
            case (addr)
                ADDR_DATA: begin
                    cs_next   = Peripheral_in[1:0];
                    led_next  = Peripheral_in[LED_W+1:2];
                    gpio_next = Peripheral_in[LED_W+2 +: GPIO_W];
                end
                ADDR_SET: begin
                    led_next = led_reg | Peripheral_in[LED_W-1:0];
                end
                ADDR_CLR: begin
                    led_next = led_reg & ~Peripheral_in[LED_W-1:0];
                end
                ADDR_BLINK: begin
                    blink_mask_next = Peripheral_in[LED_W-1:0];
                    blink_half_next = Peripheral_in[31:16];
                end
            endcase
        end
    end

    // Blink engine: free-running prescaler, half-period counter, phase flop.
    // A BLINK write overrides everything, including a coincident tick.
    always_comb begin
        tick          = (presc_reg == PRESC_MAX);
        presc_next    = tick ? '0 : presc_reg + PRESC_W'(1);
        half_cnt_next = half_cnt_reg;
        phase_next    = phase_reg;
        if (blink_half_reg == 16'd0) begin
            // Disabled: hold the engine at rest but let the prescaler run.
            half_cnt_next = '0;
            phase_next    = 1'b0;
        end else if (tick) begin
            if (half_cnt_reg == blink_half_reg - 16'd1) begin
                half_cnt_next = '0;
                phase_next    = ~phase_reg;
            end else begin
                half_cnt_next = half_cnt_reg + 16'd1;
            end
        end
        if (blink_wr) begin
            presc_next    = '0;
            half_cnt_next = '0;
            phase_next    = 1'b0;
        end
    end

    // Per-LED masking uses next-state values so led_out tracks led_reg with no extra delay.
    genvar gi;
    generate
        for (gi = 0; gi < LED_W; gi++) begin : g_led_mask
            assign led_out_next[gi] = led_next[gi] & ~(blink_mask_next[gi] & phase_next);
        end
    endgenerate

    // State update with synchronous reset; reset also idles the blink engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_reg         <= '0;
            led_reg        <= '0;
            gpio_reg       <= '0;
            blink_mask_reg <= '0;
            blink_half_reg <= '0;
            presc_reg      <= '0;
            half_cnt_reg   <= '0;
            phase_reg      <= 1'b0;
            led_out_reg    <= '0;
        end else begin
            cs_reg         <= cs_next;
            led_reg        <= led_next;
            gpio_reg       <= gpio_next;
            blink_mask_reg <= blink_mask_next;
            blink_half_reg <= blink_half_next;
            presc_reg      <= presc_next;
            half_cnt_reg   <= half_cnt_next;
            phase_reg      <= phase_next;
            led_out_reg    <= led_out_next;
        end
    end

    // Readback mux; depends only on addr and registered state.
    // For LED_W > 16 the upper mask bits share the blink_half field, so
    // blink_half is laid over the mask in the BLINK view.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA:  rd_data = {gpio_reg, led_reg, cs_reg};
            ADDR_SET,
            ADDR_CLR:   rd_data = 32'(led_out_reg);
            ADDR_BLINK: begin
                rd_data        = 32'(blink_mask_reg);
                rd_data[31:16] = blink_half_reg;
            end
        endcase
    end

    assign counter_set = cs_reg;
    assign GPIOf0      = gpio_reg;
    assign led_out     = led_out_reg;

endmodule
